ula_arbiter: RTL and testbench

- Shares one ula instance (ALU) between two requesters (port 0, port 1) using valid/ready handshakes and round-robin arbitration.
- Registers the winning operands, drives the ALU for one execute cycle, then captures result and flags.
- Presents the captured result and flags on a response channel, tagged with the requester id.
- Sits between instruction-issue logic and the shared ula; the ula itself stays external and combinational.

---
 rtl/ula_arbiter.sv | 159 +++++++++++++++
 tb/tb_ula_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one external combinational ula between two requesters.
// Optional unsigned-compare response outputs are enabled with `define ULA_ARBITER_CMP_EN.
module ula_arbiter #(
    parameter int ULA_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ULA_BITS-1:0] req0_a,
    input  logic [ULA_BITS-1:0] req0_b,
    input  logic [2:0]          req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ULA_BITS-1:0] req1_a,
    input  logic [ULA_BITS-1:0] req1_b,
    input  logic [2:0]          req1_op,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [ULA_BITS-1:0] resp_result,
    output logic                resp_zero,
    output logic                resp_carry,
    output logic                resp_overflow,
    output logic                resp_negative,
`ifdef ULA_ARBITER_CMP_EN
    output logic                resp_hs,
    output logic                resp_ls,
    output logic                resp_hi,
    output logic                resp_lo,
`endif
    output logic [ULA_BITS-1:0] alu_a,
    output logic [ULA_BITS-1:0] alu_b,
    output logic [2:0]          alu_ctrl,
    input  logic [ULA_BITS-1:0] alu_result,
    input  logic                alu_zero,
    input  logic                alu_carry,
    input  logic                alu_overflow,
    input  logic                alu_negative
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                id_q, id_d;
    logic [ULA_BITS-1:0] a_q, a_d;
    logic [ULA_BITS-1:0] b_q, b_d;
    logic [2:0]          op_q, op_d;
    logic [ULA_BITS-1:0] result_q, result_d;
    logic [3:0]          flags_q, flags_d;   // {zero, carry, overflow, negative}

    logic                have_req;
    logic                winner;
    logic                grant_en;

`ifdef ULA_ARBITER_CMP_EN
    logic [3:0]          cmp_q, cmp_d;       // {hs, ls, hi, lo}
`endif

    // Winner: the sole valid port, or on a tie the port that did not win last.
    assign have_req = req0_valid | req1_valid;
    assign winner   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    // Ready is gated by rst_n so nothing is offered while reset is held.
    assign grant_en   = rst_n && (state_q == ST_IDLE) && have_req;
    assign req0_ready = grant_en && !winner;
    assign req1_ready = grant_en && winner;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        flags_d      = flags_q;
`ifdef ULA_ARBITER_CMP_EN
        cmp_d        = cmp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (have_req) begin
                    last_grant_d = winner;
                    id_d         = winner;
                    a_d          = winner ? req1_a  : req0_a;
                    b_d          = winner ? req1_b  : req0_b;
                    op_d         = winner ? req1_op : req0_op;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                flags_d  = {alu_zero, alu_carry, alu_overflow, alu_negative};
`ifdef ULA_ARBITER_CMP_EN
                cmp_d    = {alu_carry, ~alu_carry | alu_zero,
                            alu_carry & ~alu_zero, ~alu_carry};
`endif
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            flags_q      <= '0;
`ifdef ULA_ARBITER_CMP_EN
            cmp_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
`ifdef ULA_ARBITER_CMP_EN
            cmp_q        <= cmp_d;
`endif
        end
    end

    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_ctrl      = op_q;
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_id       = id_q;
    assign resp_result   = result_q;
    assign resp_zero     = flags_q[3];
    assign resp_carry    = flags_q[2];
    assign resp_overflow = flags_q[1];
    assign resp_negative = flags_q[0];
`ifdef ULA_ARBITER_CMP_EN
    assign resp_hs       = cmp_q[3];
    assign resp_ls       = cmp_q[2];
    assign resp_hi       = cmp_q[1];
    assign resp_lo       = cmp_q[0];
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Randomized self-checking bench for ula_arbiter against a transaction-level model
// with a behavioural ula attached to the alu_* ports.
module tb_ula_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         resp_valid, resp_ready, resp_id;
    logic [W-1:0] resp_result;
    logic         resp_zero, resp_carry, resp_overflow, resp_negative;
`ifdef ULA_ARBITER_CMP_EN
    logic         resp_hs, resp_ls, resp_hi, resp_lo;
`endif
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_ctrl;
    logic         alu_zero, alu_carry, alu_overflow, alu_negative;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ula_arbiter #(.ULA_BITS(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_carry(resp_carry),
        .resp_overflow(resp_overflow), .resp_negative(resp_negative),
`ifdef ULA_ARBITER_CMP_EN
        .resp_hs(resp_hs), .resp_ls(resp_ls), .resp_hi(resp_hi), .resp_lo(resp_lo),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_negative(alu_negative)
    );

    // Behavioural ula: returns {result, zero, carry, overflow, negative}.
    function automatic logic [W+3:0] ula_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd6: r = ~(a | b);
            default: r = b;
        endcase
        return {r, (r == '0), c, v, r[W-1]};
    endfunction

    always_comb begin
        {alu_result, alu_zero, alu_carry, alu_overflow, alu_negative} =
            ula_model(alu_a, alu_b, alu_ctrl);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: at most one operation in flight, aged in cycles.
    bit           pend;
    int           age;
    bit           p_id;
    logic [W-1:0] p_a, p_b;
    logic [2:0]   p_op;
    bit           last_g;
    int           cyc;
    int           last_consume;
    int           acc_cyc[$];
    bit           acc_id[$];

    task automatic model_reset();
        pend = 1'b0; age = 0; last_g = 1'b1;
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model.
    task automatic step(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [2:0] op0, input bit v1, input logic [W-1:0] a1,
                        input logic [W-1:0] b1, input logic [2:0] op1, input bit rr);
        bit           has, win, exp_v;
        logic [W+3:0] e;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        resp_ready = rr;
        @(negedge clk);
        has   = v0 | v1;
        win   = (v0 && v1) ? !last_g : v1;
        exp_v = pend && (age >= 2);
        chk("req0_ready", req0_ready, !pend && has && !win);
        chk("req1_ready", req1_ready, !pend && has && win);
        chk("resp_valid", resp_valid, exp_v);
        if (pend && age == 1) begin
            chk("alu_a", alu_a, p_a);
            chk("alu_b", alu_b, p_b);
            chk("alu_ctrl", alu_ctrl, p_op);
        end
        if (exp_v) begin
            e = ula_model(p_a, p_b, p_op);
            chk("resp_id", resp_id, p_id);
            chk("resp_result", resp_result, e[W+3:4]);
            chk("resp_zero", resp_zero, e[3]);
            chk("resp_carry", resp_carry, e[2]);
            chk("resp_overflow", resp_overflow, e[1]);
            chk("resp_negative", resp_negative, e[0]);
`ifdef ULA_ARBITER_CMP_EN
            chk("resp_hs", resp_hs, e[2]);
            chk("resp_ls", resp_ls, !e[2] || e[3]);
            chk("resp_hi", resp_hi, e[2] && !e[3]);
            chk("resp_lo", resp_lo, !e[2]);
`endif
        end
        if (exp_v && rr) begin
            pend = 1'b0;
            last_consume = cyc;
        end else if (pend) begin
            age++;
        end else if (has) begin
            pend = 1'b1; age = 1; p_id = win; last_g = win;
            p_a  = win ? a1 : a0;
            p_b  = win ? b1 : b0;
            p_op = win ? op1 : op0;
            acc_cyc.push_back(cyc);
            acc_id.push_back(win);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step(input int pv, input int pr);
        step($urandom_range(99) < pv, W'($urandom), W'($urandom), 3'($urandom),
             $urandom_range(99) < pv, W'($urandom), W'($urandom), 3'($urandom),
             $urandom_range(99) < pr);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy0"}, req0_ready, 0);
        chk({tag, "_rdy1"}, req1_ready, 0);
        chk({tag, "_valid"}, resp_valid, 0);
        chk({tag, "_id"}, resp_id, 0);
        chk({tag, "_result"}, resp_result, 0);
        chk({tag, "_flags"}, {resp_zero, resp_carry, resp_overflow, resp_negative}, 0);
        chk({tag, "_alu"}, {alu_a, alu_b, alu_ctrl}, 0);
    endtask

    initial begin
        cyc = 0; last_consume = 0;
        model_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("first_grant", {req1_ready, req0_ready}, 2'b01);
        step(1, 4'd9, 4'd2, 3'd4, 1, 4'd1, 4'd1, 3'd0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Single add from port 0.
        step(1, 4'b0011, 4'b0100, 3'b000, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("add_valid", resp_valid, 1);
        chk("add_id", resp_id, 0);
        chk("add_result", resp_result, 4'b0111);
        chk("add_zc", {resp_zero, resp_carry}, 2'b00);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Subtract to zero from port 1.
        step(0, 0, 0, 0, 1, 4'b0101, 4'b0101, 3'b001, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("sub_valid", resp_valid, 1);
        chk("sub_id", resp_id, 1);
        chk("sub_result", resp_result, 4'b0000);
        chk("sub_zc", {resp_zero, resp_carry}, 2'b11);
`ifdef ULA_ARBITER_CMP_EN
        chk("sub_cmp", {resp_hs, resp_ls, resp_hi, resp_lo}, 4'b1100);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Contention: both ports always valid.
        acc_cyc.delete(); acc_id.delete();
        for (int i = 0; i < 12; i++) begin
            step(1, W'($urandom), W'($urandom), 3'($urandom),
                 1, W'($urandom), W'($urandom), 3'($urandom), 1);
        end
        chk("contend_count", acc_cyc.size(), 4);
        for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
            chk("contend_id", acc_id[i], i % 2);
            if (i > 0) chk("contend_gap", acc_cyc[i] - acc_cyc[i-1], 3);
        end
        while (pend) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Backpressure in RESP, with upstream churn.
        step(1, 4'd7, 4'd12, 3'd0, 0, 0, 0, 0, 0);
        step(1, W'($urandom), W'($urandom), 3'($urandom), 1, 4'd3, 4'd3, 3'd1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, W'($urandom), W'($urandom), 3'($urandom),
                 1, W'($urandom), W'($urandom), 3'($urandom), 0);
        end
        chk("bp_result", resp_result, 4'd3);
        chk("bp_carry", resp_carry, 1);
        acc_cyc.delete();
        step(1, 4'd1, 4'd2, 3'd3, 1, 4'd5, 4'd6, 3'd2, 1);
        step(1, 4'd1, 4'd2, 3'd3, 1, 4'd5, 4'd6, 3'd2, 1);
        chk("bp_accept_count", acc_cyc.size(), 1);
        if (acc_cyc.size() > 0) chk("bp_accept_gap", acc_cyc[0] - last_consume, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) rand_step(60, 60);
        while (pend) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset in the EXEC cycle discards the operation.
        step(1, 4'd6, 4'd1, 3'd0, 1, 4'd2, 4'd2, 3'd0, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_exec");
        @(negedge clk);
        chk("rst_exec_hold_valid", resp_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("regrant_port0", {req1_ready, req0_ready}, 2'b01);
        step(1, 4'd2, 4'd3, 3'd0, 1, 4'd4, 4'd4, 3'd1, 1);
        for (int i = 0; i < 200; i++) rand_step(70, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
